// File: rtl/linebuf_seq.sv
// -----------------------------------------------------------------------------
// linebuf_seq
//   Bus master that sequences one line-buffer capture from the read-clock
//   domain. It programs the line window, kicks the capture, polls for the kick
//   acknowledge, then drains the capture FIFO one byte at a time (status read,
//   data read, ...) and streams the bytes out over a valid/ready port.
//
// Ports
//   clk_i, reset_i        clock, asynchronous active-high reset
//   start_i               1-cycle start pulse (only looked at while idle)
//   abort_i               level; stop after the in-flight bus transaction
//   cfg_line_addr_i [8:0] first captured line
//   cfg_line_size_i [4:0] number of lines (1..31)
//   cfg_line_width_i[10:0] bytes per line
//   busy_o                high in every state except IDLE
//   done_o                1-cycle pulse once every byte has been streamed
//   error_o, err_code_o   sticky error flag/code (1 cfg, 2 kick timeout,
//                         3 FIFO overflow/underflow), cleared by next start
//   MCmd_o/MAddr_o/MData_o  register bus command (001 write, 010 read)
//   SCmdAccept_i, SData_i, SResp_i  register bus slave side
//   out_data_o/out_valid_o/out_ready_i/out_last_o  byte stream
// -----------------------------------------------------------------------------
module linebuf_seq #(
  parameter int FIFO_DEPTH = 32768,
  parameter int TIMEOUT    = 2**20
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [8:0]  cfg_line_addr_i,
  input  logic [4:0]  cfg_line_size_i,
  input  logic [10:0] cfg_line_width_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [1:0]  err_code_o,
  output logic [2:0]  MCmd_o,
  output logic [7:0]  MAddr_o,
  output logic [7:0]  MData_o,
  input  logic        SCmdAccept_i,
  input  logic [7:0]  SData_i,
  input  logic [1:0]  SResp_i,
  output logic [7:0]  out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_last_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_AL, S_WR_AH, S_WR_SZ, S_WR_GO,
    S_POLL, S_STAT, S_DATA, S_LAST, S_FIN, S_STOP
  } state_t;

  localparam logic [2:0]  CMD_IDLE = 3'b000;
  localparam logic [2:0]  CMD_WR   = 3'b001;
  localparam logic [2:0]  CMD_RD   = 3'b010;
  localparam logic [7:0]  REG_DATA = 8'h00;
  localparam logic [7:0]  REG_KICK = 8'h10;
  localparam logic [7:0]  REG_ALO  = 8'h20;
  localparam logic [7:0]  REG_AHI  = 8'h21;
  localparam logic [7:0]  REG_SIZE = 8'h30;
  localparam logic [7:0]  REG_STAT = 8'h70;
  localparam logic [16:0] DEPTH_L  = 17'(FIFO_DEPTH);
  localparam int          TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  state_t        state_q;
  logic [2:0]    mcmd_q;
  logic [7:0]    maddr_q, mdata_q;
  logic          wait_resp_q;
  logic          addr_hi_q;
  logic [4:0]    size_q;
  logic [15:0]   total_q, count_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    out_data_q;
  logic          out_valid_q, out_last_q;
  logic          error_q;
  logic [1:0]    err_code_q;

  logic [15:0] total_d, count_d;
  logic        cfg_bad, acc, wr_done, rsp, bus_idle, out_hs, out_free, abortable;

  assign total_d  = 16'(cfg_line_size_i) * 16'(cfg_line_width_i);
  assign cfg_bad  = (cfg_line_size_i == '0) || (cfg_line_width_i == '0) ||
                    ({1'b0, total_d} > DEPTH_L);
  assign count_d  = count_q + 16'd1;
  assign acc      = (mcmd_q != CMD_IDLE) && SCmdAccept_i;
  assign wr_done  = acc && (mcmd_q == CMD_WR);
  assign rsp      = wait_resp_q && (SResp_i == 2'b01);
  assign bus_idle = (mcmd_q == CMD_IDLE) && !wait_resp_q;
  assign out_hs   = out_valid_q && out_ready_i;
  // The output register is free if empty or being drained this very cycle.
  assign out_free = !out_valid_q || out_ready_i;
  assign abortable = (state_q != S_IDLE) && (state_q != S_FIN) && (state_q != S_STOP);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      mcmd_q      <= CMD_IDLE;
      maddr_q     <= '0;
      mdata_q     <= '0;
      wait_resp_q <= 1'b0;
      addr_hi_q   <= 1'b0;
      size_q      <= '0;
      total_q     <= '0;
      count_q     <= '0;
      tmo_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= '0;
    end else begin
      // Bus bookkeeping; state actions below may issue the next command.
      if (acc) begin
        mcmd_q      <= CMD_IDLE;
        wait_resp_q <= (mcmd_q == CMD_RD);
      end
      if (rsp) wait_resp_q <= 1'b0;
      if (out_hs) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      if (state_q == S_POLL && tmo_q != TMO_MAX) tmo_q <= tmo_q + TW'(1);

      // Abort only once the bus has nothing in flight; late read data is dropped.
      if (abort_i && abortable && (bus_idle || wr_done || rsp)) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        mcmd_q      <= CMD_WR;
        maddr_q     <= REG_KICK;
        mdata_q     <= 8'h00;
        state_q     <= S_STOP;
      end else begin
        case (state_q)
          S_IDLE: if (start_i) begin
            if (cfg_bad) begin
              error_q    <= 1'b1;
              err_code_q <= 2'd1;
            end else begin
              error_q    <= 1'b0;
              err_code_q <= 2'd0;
              addr_hi_q  <= cfg_line_addr_i[8];
              size_q     <= cfg_line_size_i;
              total_q    <= total_d;
              count_q    <= '0;
              mcmd_q     <= CMD_WR;
              maddr_q    <= REG_ALO;
              mdata_q    <= cfg_line_addr_i[7:0];
              state_q    <= S_WR_AL;
            end
          end
          S_WR_AL: if (wr_done) begin
            mcmd_q  <= CMD_WR;
            maddr_q <= REG_AHI;
            mdata_q <= {7'd0, addr_hi_q};
            state_q <= S_WR_AH;
          end
          S_WR_AH: if (wr_done) begin
            mcmd_q  <= CMD_WR;
            maddr_q <= REG_SIZE;
            mdata_q <= {3'd0, size_q};
            state_q <= S_WR_SZ;
          end
          S_WR_SZ: if (wr_done) begin
            mcmd_q  <= CMD_WR;
            maddr_q <= REG_KICK;
            mdata_q <= 8'h01;
            state_q <= S_WR_GO;
          end
          S_WR_GO: if (wr_done) begin
            tmo_q   <= '0;
            mcmd_q  <= CMD_RD;
            maddr_q <= REG_KICK;
            state_q <= S_POLL;
          end
          S_POLL: if (rsp) begin
            if (!SData_i[0]) begin
              mcmd_q  <= CMD_RD;
              maddr_q <= REG_STAT;
              state_q <= S_STAT;
            end else if (tmo_q >= TMO_MAX) begin
              // Kick never acknowledged: withdraw it and report.
              error_q    <= 1'b1;
              err_code_q <= 2'd2;
              mcmd_q     <= CMD_WR;
              maddr_q    <= REG_KICK;
              mdata_q    <= 8'h00;
              state_q    <= S_STOP;
            end else begin
              mcmd_q  <= CMD_RD;
              maddr_q <= REG_KICK;
            end
          end
          S_STAT: if (rsp) begin
            if (SData_i[5] || SData_i[1]) begin
              error_q     <= 1'b1;
              err_code_q  <= 2'd3;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= S_IDLE;
            end else if (SData_i[0]) begin
              mcmd_q  <= CMD_RD;
              maddr_q <= REG_STAT;
            end else begin
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            if (bus_idle && out_free) begin
              mcmd_q  <= CMD_RD;
              maddr_q <= REG_DATA;
            end
            if (rsp) begin
              out_data_q  <= SData_i;
              out_valid_q <= 1'b1;
              out_last_q  <= (count_d == total_q);
              count_q     <= count_d;
              if (count_d == total_q) begin
                state_q <= S_LAST;
              end else begin
                mcmd_q  <= CMD_RD;
                maddr_q <= REG_STAT;
                state_q <= S_STAT;
              end
            end
          end
          S_LAST: if (out_hs) state_q <= S_FIN;
          S_FIN:  state_q <= S_IDLE;
          S_STOP: if (wr_done) state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_FIN);
  assign error_o     = error_q;
  assign err_code_o  = err_code_q;
  assign MCmd_o      = mcmd_q;
  assign MAddr_o     = maddr_q;
  assign MData_o     = mdata_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_linebuf_seq.sv
// -----------------------------------------------------------------------------
// tb_linebuf_seq
//   Directed bench for linebuf_seq. A small register-bus slave models the line
//   buffer (kick register, status sequence, incrementing data bytes) and logs
//   every accepted write; a sink records every streamed byte.
// -----------------------------------------------------------------------------
module tb_linebuf_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [8:0]  addr;
  logic [4:0]  size;
  logic [10:0] width;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [2:0]  MCmd;
  logic [7:0]  MAddr, MData;
  logic        SCmdAccept;
  logic [7:0]  SData;
  logic [1:0]  SResp;
  logic [7:0]  out_data;
  logic        out_valid, out_ready, out_last;

  linebuf_seq #(.FIFO_DEPTH(32768), .TIMEOUT(64)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .abort_i(abort),
    .cfg_line_addr_i(addr), .cfg_line_size_i(size), .cfg_line_width_i(width),
    .busy_o(busy), .done_o(done), .error_o(error), .err_code_o(err_code),
    .MCmd_o(MCmd), .MAddr_o(MAddr), .MData_o(MData),
    .SCmdAccept_i(SCmdAccept), .SData_i(SData), .SResp_i(SResp),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_last_o(out_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

  // slave model state
  int         stall_cnt = 0;
  bit         never_clear = 1'b0;
  int         kick_polls = 2;
  bit         kick_val = 1'b0;
  int         kick_cnt = 0;
  logic [7:0] stat_seq [16];
  int         stat_n = 0, stat_len = 0;
  bit         last_empty = 1'b0;
  int         stat_reads = 0, data_reads = 0, bad_reads = 0;
  logic [7:0] data_val = 8'hA0;
  logic [7:0] lw_addr [128];
  logic [7:0] lw_data [128];
  int         nlog = 0;
  int         go_cyc = 0;
  bit         resp_pend = 1'b0;
  logic [7:0] resp_data = 8'h00;

  // sink state
  logic [7:0] rx_data [128];
  logic       rx_last [128];
  int         rx_n = 0;
  int         done_cnt = 0;

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  // Slave: decides acceptance at the negedge before the edge that takes the
  // command; read data is presented for the cycle after acceptance.
  initial begin
    SCmdAccept = 1'b0;
    SResp      = 2'b00;
    SData      = 8'h00;
    forever begin
      @(negedge clk);
      SResp = 2'b00;
      if (resp_pend) begin
        SResp     = 2'b01;
        SData     = resp_data;
        resp_pend = 1'b0;
      end
      SCmdAccept = 1'b0;
      if (!rst && MCmd != 3'b000) begin
        if (stall_cnt > 0) begin
          stall_cnt--;
        end else begin
          SCmdAccept = 1'b1;
          if (MCmd == 3'b001) begin
            if (nlog < 128) begin
              lw_addr[nlog] = MAddr;
              lw_data[nlog] = MData;
            end
            nlog++;
            if (MAddr == 8'h10) begin
              kick_val = MData[0];
              kick_cnt = 0;
              if (MData[0]) go_cyc = cyc_cnt;
            end
          end else begin
            case (MAddr)
              8'h10: begin
                resp_data = {7'd0, kick_val && (never_clear || kick_cnt < kick_polls)};
                kick_cnt++;
              end
              8'h70: begin
                resp_data = (stat_n < stat_len) ? stat_seq[stat_n] : 8'h00;
                stat_n++;
                last_empty = resp_data[0];
                stat_reads++;
              end
              default: begin
                if (last_empty) bad_reads++;
                resp_data = data_val;
                data_val++;
                data_reads++;
              end
            endcase
            resp_pend = 1'b1;
          end
        end
      end
    end
  end

  // Sink: a byte is taken at the coming posedge when valid & ready now.
  initial forever begin
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (rx_n < 128) begin
        rx_data[rx_n] = out_data;
        rx_last[rx_n] = out_last;
      end
      rx_n++;
    end
    if (done) done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      tick(1);
      n++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_rx(input string tag, input int target, input int bound);
    int n = 0;
    while (rx_n < target && n < bound) begin
      tick(1);
      n++;
    end
    chk({tag, "_rx_reached"}, {31'd0, rx_n >= target}, 32'd1);
  endtask

  task automatic pulse_start(input logic [8:0] a, input logic [4:0] s, input logic [10:0] w);
    addr  = a;
    size  = s;
    width = w;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  int         lb, rb, db, sb, dr, n, err_cyc, snap_reads;
  logic [7:0] base, snap_d;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    addr = '0; size = '0; width = '0; out_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("rst_mcmd", 32'(MCmd), 32'd0);
    chk("rst_maddr", 32'(MAddr), 32'd0);
    chk("rst_mdata", 32'(MData), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_errcode", 32'(err_code), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);

    // T1: addr 0x105, 2 lines x 4 bytes, first command stalled 3 cycles
    kick_polls = 2; stat_n = 0; stat_len = 0; stall_cnt = 3;
    lb = nlog; rb = rx_n; db = done_cnt; base = data_val;
    pulse_start(9'h105, 5'd2, 11'd4);
    chk("t1_busy", 32'(busy), 32'd1);
    tick(1);
    chk("t1_hold_cmd", {MCmd, MAddr, MData}, {8'd0, 3'b001, 8'h20, 8'h05});
    wait_idle("t1", 300);
    chk("t1_nwrites", 32'(nlog - lb), 32'd4);
    chk("t1_wr0", {lw_addr[lb], lw_data[lb]}, 32'h2005);
    chk("t1_wr1", {lw_addr[lb+1], lw_data[lb+1]}, 32'h2101);
    chk("t1_wr2", {lw_addr[lb+2], lw_data[lb+2]}, 32'h3002);
    chk("t1_wr3", {lw_addr[lb+3], lw_data[lb+3]}, 32'h1001);
    chk("t1_nbytes", 32'(rx_n - rb), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_byte%0d", i), 32'(rx_data[rb+i]), 32'(8'(base + 8'(i))));
      chk($sformatf("t1_last%0d", i), 32'(rx_last[rb+i]), 32'(i == 7));
    end
    chk("t1_done_pulses", 32'(done_cnt - db), 32'd1);
    chk("t1_error", 32'(error), 32'd0);
    $display("T1 write/stream 2x4 bytes: rx=%0d done=%0d", rx_n - rb, done_cnt - db);

    // T2: status reports empty five times before the first byte
    for (int i = 0; i < 5; i++) stat_seq[i] = 8'h01;
    stat_n = 0; stat_len = 5;
    sb = stat_reads; dr = data_reads; rb = rx_n; base = data_val;
    pulse_start(9'h010, 5'd1, 11'd2);
    wait_idle("t2", 300);
    chk("t2_stat_reads", 32'(stat_reads - sb), 32'd7);
    chk("t2_data_reads", 32'(data_reads - dr), 32'd2);
    chk("t2_no_read_empty", 32'(bad_reads), 32'd0);
    chk("t2_byte1", 32'(rx_data[rb+1]), 32'(8'(base + 8'd1)));
    $display("T2 empty status x5: stat_reads=%0d data_reads=%0d", stat_reads - sb, data_reads - dr);

    // T3: downstream stalls mid-stream
    stat_n = 0; stat_len = 0;
    rb = rx_n; base = data_val;
    pulse_start(9'h020, 5'd1, 11'd6);
    wait_rx("t3", rb + 2, 200);
    out_ready = 1'b0;
    tick(8);
    chk("t3_valid_stall", 32'(out_valid), 32'd1);
    snap_d = out_data;
    snap_reads = data_reads;
    tick(10);
    chk("t3_valid_held", 32'(out_valid), 32'd1);
    chk("t3_data_held", 32'(out_data), 32'(snap_d));
    chk("t3_no_data_read", 32'(data_reads), 32'(snap_reads));
    out_ready = 1'b1;
    wait_idle("t3", 300);
    chk("t3_nbytes", 32'(rx_n - rb), 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t3_byte%0d", i), 32'(rx_data[rb+i]), 32'(8'(base + 8'(i))));
    $display("T3 ready stall: rx=%0d held=%0h", rx_n - rb, snap_d);

    // T4: rejected configurations
    lb = nlog;
    pulse_start(9'h001, 5'd0, 11'd4);
    tick(3);
    chk("t4a_error", 32'(error), 32'd1);
    chk("t4a_code", 32'(err_code), 32'd1);
    chk("t4a_busy", 32'(busy), 32'd0);
    chk("t4a_nobus", 32'(nlog - lb), 32'd0);
    pulse_start(9'h001, 5'd31, 11'd2047);
    tick(3);
    chk("t4b_error", 32'(error), 32'd1);
    chk("t4b_code", 32'(err_code), 32'd1);
    chk("t4b_busy", 32'(busy), 32'd0);
    chk("t4b_nobus", 32'(nlog - lb), 32'd0);
    chk("t4_mcmd", 32'(MCmd), 32'd0);
    $display("T4 bad cfg: error=%0d code=%0d", error, err_code);

    // T5: kick never acknowledged
    never_clear = 1'b1;
    lb = nlog;
    pulse_start(9'h003, 5'd1, 11'd1);
    chk("t5_err_cleared", 32'(error), 32'd0);
    n = 0;
    while (!error && n < 300) begin
      tick(1);
      n++;
    end
    err_cyc = cyc_cnt;
    chk("t5_error", 32'(error), 32'd1);
    chk("t5_code", 32'(err_code), 32'd2);
    chk("t5_tmo_window", 32'((err_cyc - go_cyc) >= 64 && (err_cyc - go_cyc) <= 72), 32'd1);
    wait_idle("t5", 50);
    chk("t5_nwrites", 32'(nlog - lb), 32'd5);
    chk("t5_unkick", {lw_addr[nlog-1], lw_data[nlog-1]}, 32'h1000);
    never_clear = 1'b0;
    $display("T5 kick timeout: cycles=%0d code=%0d", err_cyc - go_cyc, err_code);

    // T6: overflow flagged by the third status read
    stat_seq[0] = 8'h00; stat_seq[1] = 8'h00; stat_seq[2] = 8'h20;
    stat_n = 0; stat_len = 3;
    rb = rx_n; db = done_cnt;
    pulse_start(9'h004, 5'd1, 11'd4);
    wait_idle("t6", 300);
    chk("t6_error", 32'(error), 32'd1);
    chk("t6_code", 32'(err_code), 32'd3);
    chk("t6_nbytes", 32'(rx_n - rb), 32'd2);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_no_done", 32'(done_cnt - db), 32'd0);
    $display("T6 overflow: code=%0d rx=%0d", err_code, rx_n - rb);

    // T7: abort while draining
    stat_n = 0; stat_len = 0;
    rb = rx_n; db = done_cnt; lb = nlog;
    pulse_start(9'h005, 5'd2, 11'd8);
    wait_rx("t7", rb + 4, 300);
    abort = 1'b1;
    wait_idle("t7", 50);
    abort = 1'b0;
    tick(2);
    chk("t7_no_done", 32'(done_cnt - db), 32'd0);
    chk("t7_error", 32'(error), 32'd0);
    chk("t7_valid", 32'(out_valid), 32'd0);
    chk("t7_partial", 32'((rx_n - rb) < 16), 32'd1);
    chk("t7_unkick", {lw_addr[nlog-1], lw_data[nlog-1]}, 32'h1000);
    chk("t7_mcmd", 32'(MCmd), 32'd0);
    $display("T7 abort: rx=%0d writes=%0d", rx_n - rb, nlog - lb);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
